jericalla_fetch: RTL and testbench
==================================

Name: jericalla_fetch

Overview:
Parametrised instruction-fetch stage for the next-generation Jericalla core. It replaces the fixed 4-bit free-running PC with a controlled program counter and adds an instruction register (IR) between instruction memory and the datapath. It also adds start/halt control, stall, branch-on-zero with a one-bubble flush, and a fetch counter. It sits between the external instruction memory (combinational read) and the Jericalla datapath.

Parameters:
PC_WIDTH, 4, program-counter / instruction-memory address width
INST_WIDTH, 18, instruction word width
LAST_ADDR, 15, address of the final program word; must be < 2**PC_WIDTH
WRAP, 1, 1 = PC wraps to 0 after LAST_ADDR; 0 = enter HALT after fetching LAST_ADDR
COUNT_WIDTH, 16, width of the fetch counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; leaves IDLE or HALT and begins fetching from address 0
stall  in  1  hold PC and IR this cycle
halt_req  in  1  stop fetching; enter HALT
branch_en  in  1  datapath requests branch-if-zero for the instruction in IR
zf  in  1  zero flag from datapath
branch_target  in  PC_WIDTH  absolute branch destination
imem_addr  out  PC_WIDTH  instruction memory address (= pc, combinational)
imem_data  in  INST_WIDTH  instruction memory read data, valid same cycle
ir  out  INST_WIDTH  registered instruction to datapath
ir_valid  out  1  ir holds a real instruction this cycle
running  out  1  state == RUN
halted  out  1  state == HALT
fetch_count  out  COUNT_WIDTH  number of instructions loaded into IR with valid=1

Behaviour:
- Reset (async, any time, including mid-run): pc=0, ir=0, ir_valid=0, fetch_count=0, state=IDLE, running=0, halted=0. Outputs are at these values while reset is high.
- States: IDLE, RUN, HALT. Encoding lives in the package.
- IDLE: pc=0, ir_valid=0. start -> RUN next edge. pc stays 0, so the first fetch is address 0 in the first RUN cycle.
- RUN, per edge, priority high to low:
  1. halt_req: -> HALT; ir_valid<=0; pc holds.
  2. branch taken (branch_en & zf): pc<=branch_target; ir_valid<=0, flushing the wrong-path word. Overrides stall. Exactly one bubble.
  3. stall: pc, ir, ir_valid, fetch_count hold.
  4. normal: ir<=imem_data; ir_valid<=1; fetch_count+1.
     - If pc==LAST_ADDR and WRAP=1: pc<=0.
     - If pc==LAST_ADDR and WRAP=0: pc holds, state -> HALT next edge. The LAST_ADDR word is still loaded with ir_valid=1 for that one cycle.
     - Otherwise: pc<=pc+1, modulo 2**PC_WIDTH.
- branch_en with zf=0: not taken, treated as normal or stall per the rules above.
- Branch target beyond LAST_ADDR: accepted as-is, no clamping.
- HALT: pc, ir, fetch_count frozen; ir_valid=0; halted=1. start -> RUN with pc<=0. fetch_count is not cleared; only reset clears it.
- start while in RUN: ignored.
- fetch_count wraps modulo 2**COUNT_WIDTH. It increments only on loads with valid=1.
- Latency: the word at address A appears on ir one edge after pc==A, in an unstalled RUN cycle.

Decomposition:
- Package jericalla_pkg holds: state typedef {IDLE, RUN, HALT}, default widths (PC_WIDTH=4, INST_WIDTH=18, DATA_WIDTH=32).
- One sub-module, jericalla_pc: PC register with load/hold/increment/wrap, parametrised by PC_WIDTH and LAST_ADDR.
- FSM, IR and counter live in the top of the block.
- The block replaces PC inside the existing top-level, feeding ir to the datapath.

Test Plan:
- Reset, start, 4 unstalled cycles, imem[i]=i+100 -> ir sequence 100,101,102,103 with ir_valid=1; imem_addr 0..4; fetch_count=4.
- WRAP=1, LAST_ADDR=15, run 17 fetches -> pc goes 15->0; ir shows word 15 then word 0; no HALT.
- WRAP=0, LAST_ADDR=5 -> word 5 loaded with valid=1; next cycle halted=1, ir_valid=0, pc=5; start -> pc=0, running=1.
- Branch at pc=3 with branch_en=1, zf=1, target=9, and stall=1 in the same cycle -> next cycle pc=9, ir_valid=0; following cycle ir=imem[9]. Repeating with zf=0 -> no branch; stall holds pc=3.
- stall high 3 cycles at pc=2 -> pc, ir, fetch_count constant; resumes at address 2 on release.
- Async reset asserted mid-RUN between clock edges -> outputs zero immediately; state IDLE; start is required to resume from address 0.

Source files
------------

// File: rtl/jericalla_pkg.sv
// Shared state encoding and default widths for the Jericalla fetch stage.
package jericalla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int DEFAULT_PC_WIDTH    = 4;
    localparam int DEFAULT_INST_WIDTH  = 18;
    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_COUNT_WIDTH = 16;

endpackage

// File: rtl/jericalla_fetch_if.sv
// Control, instruction-memory and datapath-facing signals of the fetch stage.
interface jericalla_fetch_if
    import jericalla_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int INST_WIDTH  = DEFAULT_INST_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);
    logic                   start;
    logic                   stall;
    logic                   halt_req;
    logic                   branch_en;
    logic                   zf;
    logic [PC_WIDTH-1:0]    branch_target;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INST_WIDTH-1:0]  imem_data;
    logic [INST_WIDTH-1:0]  ir;
    logic                   ir_valid;
    logic                   running;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] fetch_count;

    modport master (
        input  start, stall, halt_req, branch_en, zf, branch_target, imem_data,
        output imem_addr, ir, ir_valid, running, halted, fetch_count
    );

    modport slave (
        output start, stall, halt_req, branch_en, zf, branch_target, imem_data,
        input  imem_addr, ir, ir_valid, running, halted, fetch_count
    );
endinterface

// File: rtl/jericalla_pc.sv
// Program counter: clear / load / advance (with wrap or hold at LAST_ADDR), else hold.
// Latency: new pc visible one edge after the request.
// Backpressure: none of its own; the caller withholds advance to stall.
module jericalla_pc
    import jericalla_pkg::*;
#(
    parameter int PC_WIDTH  = DEFAULT_PC_WIDTH,
    parameter int LAST_ADDR = 15,
    parameter int WRAP      = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic                advance,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                at_last
);
    logic [PC_WIDTH-1:0] pc_q;

    assign pc      = pc_q;
    assign at_last = (pc_q == PC_WIDTH'(LAST_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (clear) begin
            pc_q <= '0;
        end else if (load) begin
            pc_q <= target;
        end else if (advance) begin
            if (at_last) begin
                pc_q <= (WRAP != 0) ? '0 : pc_q;
            end else begin
                pc_q <= pc_q + PC_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/jericalla_fetch.sv
// Fetch stage: start/halt FSM, PC, instruction register and fetch counter.
// Latency: word at address A appears on ir one edge after pc==A in an unstalled RUN cycle.
// Backpressure: stall holds pc/ir/ir_valid/count; a taken branch overrides stall with one bubble.
module jericalla_fetch
    import jericalla_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int INST_WIDTH  = DEFAULT_INST_WIDTH,
    parameter int LAST_ADDR   = 15,
    parameter int WRAP        = 1,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input logic               clk,
    input logic               reset,
    jericalla_fetch_if.master bus
);
    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic                   at_last;
    logic                   taken;
    logic                   clear_pc;
    logic                   load_pc;
    logic                   advance_pc;
    logic                   last_fetched;
    logic [INST_WIDTH-1:0]  ir_q;
    logic                   ir_valid_q;
    logic                   running_q;
    logic                   halted_q;
    logic [COUNT_WIDTH-1:0] fetch_count_q;

    assign taken      = bus.branch_en & bus.zf;
    assign clear_pc   = (state == IDLE) | ((state == HALT) & bus.start);
    assign load_pc    = (state == RUN) & ~bus.halt_req & taken;
    assign advance_pc = (state == RUN) & ~bus.halt_req & ~taken & ~bus.stall
                        & ~(at_last & last_fetched);

    jericalla_pc #(
        .PC_WIDTH  (PC_WIDTH),
        .LAST_ADDR (LAST_ADDR),
        .WRAP      (WRAP)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_pc),
        .load    (load_pc),
        .advance (advance_pc),
        .target  (bus.branch_target),
        .pc      (pc),
        .at_last (at_last)
    );

    // last_fetched marks that the LAST_ADDR word already sits in ir (non-wrapping
    // build), so the next unstalled cycle halts instead of reloading it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ir_q          <= '0;
            ir_valid_q    <= 1'b0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
            last_fetched  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ir_valid_q <= 1'b0;
                    if (bus.start) begin
                        state        <= RUN;
                        running_q    <= 1'b1;
                        last_fetched <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.halt_req) begin
                        state      <= HALT;
                        running_q  <= 1'b0;
                        halted_q   <= 1'b1;
                        ir_valid_q <= 1'b0;
                    end else if (taken) begin
                        ir_valid_q   <= 1'b0;
                        last_fetched <= 1'b0;
                    end else if (!bus.stall) begin
                        if (at_last && last_fetched) begin
                            state      <= HALT;
                            running_q  <= 1'b0;
                            halted_q   <= 1'b1;
                            ir_valid_q <= 1'b0;
                        end else begin
                            ir_q          <= bus.imem_data;
                            ir_valid_q    <= 1'b1;
                            fetch_count_q <= fetch_count_q + COUNT_WIDTH'(1);
                            last_fetched  <= at_last && (WRAP == 0);
                        end
                    end
                end
                HALT: begin
                    ir_valid_q <= 1'b0;
                    if (bus.start) begin
                        state        <= RUN;
                        running_q    <= 1'b1;
                        halted_q     <= 1'b0;
                        last_fetched <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    running_q  <= 1'b0;
                    halted_q   <= 1'b0;
                    ir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.ir          = ir_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_jericalla_fetch.sv
// Directed bench: dut_a wraps at 15, dut_b halts after 5; both see the same stimulus.
module tb_jericalla_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jericalla_fetch_if #(.PC_WIDTH(4), .INST_WIDTH(18), .COUNT_WIDTH(16)) bus_a ();
    jericalla_fetch_if #(.PC_WIDTH(4), .INST_WIDTH(18), .COUNT_WIDTH(16)) bus_b ();

    jericalla_fetch #(
        .PC_WIDTH(4), .INST_WIDTH(18), .LAST_ADDR(15), .WRAP(1), .COUNT_WIDTH(16)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.master)
    );

    jericalla_fetch #(
        .PC_WIDTH(4), .INST_WIDTH(18), .LAST_ADDR(5), .WRAP(0), .COUNT_WIDTH(16)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.master)
    );

    // Instruction memory: imem[i] = i + 100
    assign bus_a.imem_data     = 18'(bus_a.imem_addr) + 18'd100;
    assign bus_b.imem_data     = 18'(bus_b.imem_addr) + 18'd100;
    assign bus_b.start         = bus_a.start;
    assign bus_b.stall         = bus_a.stall;
    assign bus_b.halt_req      = bus_a.halt_req;
    assign bus_b.branch_en     = bus_a.branch_en;
    assign bus_b.zf            = bus_a.zf;
    assign bus_b.branch_target = bus_a.branch_target;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [15:0] last_count = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; any new IR load (count moved) is popped from the scoreboard.
    task automatic tick();
        logic [31:0] want;
        @(posedge clk);
        #1;
        if (bus_a.fetch_count !== last_count) begin
            if (bus_a.ir_valid !== 1'b1) begin
                chk("load_valid", 32'(bus_a.ir_valid), 32'd1);
            end else if (exp_q.size() == 0) begin
                chk("sb_unexpected_load", exp_q.size(), 32'd1);
            end else begin
                want = exp_q.pop_front();
                chk("ir_word", 32'(bus_a.ir), want);
            end
            last_count = bus_a.fetch_count;
        end
    endtask

    task automatic step(input int addr);
        chk("imem_addr", 32'(bus_a.imem_addr), 32'(addr));
        exp_q.push_back(32'(addr + 100));
        tick();
        chk("sb_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset               = 1'b1;
        bus_a.start         = 1'b0;
        bus_a.stall         = 1'b0;
        bus_a.halt_req      = 1'b0;
        bus_a.branch_en     = 1'b0;
        bus_a.zf            = 1'b0;
        bus_a.branch_target = '0;
        #1;
        chk("rst_addr", 32'(bus_a.imem_addr), 32'd0);
        chk("rst_ir", 32'(bus_a.ir), 32'd0);
        chk("rst_valid", 32'(bus_a.ir_valid), 32'd0);
        chk("rst_count", 32'(bus_a.fetch_count), 32'd0);
        chk("rst_running", 32'(bus_a.running), 32'd0);
        chk("rst_halted", 32'(bus_a.halted), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        tick();
        chk("idle_running", 32'(bus_a.running), 32'd0);
        chk("idle_valid", 32'(bus_a.ir_valid), 32'd0);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("start_running", 32'(bus_a.running), 32'd1);

        for (int i = 0; i < 4; i++) step(i);
        chk("run4_addr", 32'(bus_a.imem_addr), 32'd4);
        chk("run4_count", 32'(bus_a.fetch_count), 32'd4);

        step(4);
        step(5);
        chk("b_last_ir", 32'(bus_b.ir), 32'd105);
        chk("b_last_valid", 32'(bus_b.ir_valid), 32'd1);
        chk("b_last_halted", 32'(bus_b.halted), 32'd0);
        step(6);
        chk("b_halted", 32'(bus_b.halted), 32'd1);
        chk("b_halt_valid", 32'(bus_b.ir_valid), 32'd0);
        chk("b_halt_addr", 32'(bus_b.imem_addr), 32'd5);
        chk("b_halt_count", 32'(bus_b.fetch_count), 32'd6);

        for (int i = 7; i < 16; i++) step(i);
        step(0);
        chk("wrap_addr", 32'(bus_a.imem_addr), 32'd1);
        chk("wrap_halted", 32'(bus_a.halted), 32'd0);
        chk("wrap_count", 32'(bus_a.fetch_count), 32'd17);
        chk("b_frozen_count", 32'(bus_b.fetch_count), 32'd6);

        // start: ignored by dut_a in RUN, restarts dut_b from HALT
        bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        chk("run_start_ignored", 32'(bus_a.imem_addr), 32'd2);
        chk("b_restart_addr", 32'(bus_b.imem_addr), 32'd0);
        chk("b_restart_running", 32'(bus_b.running), 32'd1);
        chk("b_restart_count", 32'(bus_b.fetch_count), 32'd6);

        bus_a.stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_addr", 32'(bus_a.imem_addr), 32'd2);
            chk("stall_ir", 32'(bus_a.ir), 32'd101);
            chk("stall_count", 32'(bus_a.fetch_count), 32'd18);
        end
        bus_a.stall = 1'b0;
        step(2);
        chk("unstall_count", 32'(bus_a.fetch_count), 32'd19);

        // Taken branch overrides stall
        bus_a.branch_en     = 1'b1;
        bus_a.zf            = 1'b1;
        bus_a.branch_target = 4'd9;
        bus_a.stall         = 1'b1;
        tick();
        chk("br_addr", 32'(bus_a.imem_addr), 32'd9);
        chk("br_bubble", 32'(bus_a.ir_valid), 32'd0);
        bus_a.branch_en = 1'b0;
        bus_a.zf        = 1'b0;
        bus_a.stall     = 1'b0;
        step(9);
        chk("br_valid", 32'(bus_a.ir_valid), 32'd1);

        bus_a.branch_en     = 1'b1;
        bus_a.zf            = 1'b1;
        bus_a.branch_target = 4'd3;
        tick();
        chk("br_back_addr", 32'(bus_a.imem_addr), 32'd3);
        chk("br_back_bubble", 32'(bus_a.ir_valid), 32'd0);
        bus_a.zf            = 1'b0;
        bus_a.branch_target = 4'd9;
        bus_a.stall         = 1'b1;
        tick();
        chk("nt_stall_addr", 32'(bus_a.imem_addr), 32'd3);
        chk("nt_stall_valid", 32'(bus_a.ir_valid), 32'd0);
        chk("nt_stall_count", 32'(bus_a.fetch_count), 32'd20);
        bus_a.stall = 1'b0;
        step(3);
        bus_a.branch_en = 1'b0;
        chk("nt_addr", 32'(bus_a.imem_addr), 32'd4);

        bus_a.halt_req = 1'b1;
        tick();
        bus_a.halt_req = 1'b0;
        chk("halt_halted", 32'(bus_a.halted), 32'd1);
        chk("halt_running", 32'(bus_a.running), 32'd0);
        chk("halt_valid", 32'(bus_a.ir_valid), 32'd0);
        chk("halt_addr", 32'(bus_a.imem_addr), 32'd4);
        tick();
        chk("halt_hold_addr", 32'(bus_a.imem_addr), 32'd4);
        chk("halt_hold_count", 32'(bus_a.fetch_count), 32'd21);
        chk("halt_hold_ir", 32'(bus_a.ir), 32'd103);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("resume_running", 32'(bus_a.running), 32'd1);
        chk("resume_addr", 32'(bus_a.imem_addr), 32'd0);
        chk("resume_count", 32'(bus_a.fetch_count), 32'd21);
        step(0);
        step(1);

        // Asynchronous reset between edges
        #3 reset = 1'b1;
        #1;
        chk("arst_addr", 32'(bus_a.imem_addr), 32'd0);
        chk("arst_ir", 32'(bus_a.ir), 32'd0);
        chk("arst_valid", 32'(bus_a.ir_valid), 32'd0);
        chk("arst_count", 32'(bus_a.fetch_count), 32'd0);
        chk("arst_running", 32'(bus_a.running), 32'd0);
        #2 reset = 1'b0;
        last_count = '0;
        tick();
        tick();
        chk("post_rst_idle", 32'(bus_a.running), 32'd0);
        chk("post_rst_addr", 32'(bus_a.imem_addr), 32'd0);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        step(0);
        chk("post_rst_count", 32'(bus_a.fetch_count), 32'd1);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
